// File: rtl/bb_reset_seq_if.sv
// -----------------------------------------------------------------------------
// bb_reset_seq_if
//
// Bundles the per-domain reset handshake and status signals of the reset
// release sequencer so they can be passed as a single port.
//
// Signals:
//   sw_rst_req   software reset request (level, sampled every clk edge)
//   dom_rdy      per-domain ready, synchronous to clk
//   dom_rst_n    per-domain active-low reset
//   seq_busy     sequence still in progress
//   seq_done     all domains released
//   err_timeout  sticky per-domain ready-timeout flags
//
// Modports:
//   master  sequencer side (drives resets and status, samples ready/request)
//   slave   environment side (drives ready/request, observes resets/status)
// -----------------------------------------------------------------------------
interface bb_reset_seq_if #(
  parameter int unsigned NUM_DOM = 3
);

  logic               sw_rst_req;
  logic [NUM_DOM-1:0] dom_rdy;
  logic [NUM_DOM-1:0] dom_rst_n;
  logic               seq_busy;
  logic               seq_done;
  logic [NUM_DOM-1:0] err_timeout;

  modport master (
    input  sw_rst_req,
    input  dom_rdy,
    output dom_rst_n,
    output seq_busy,
    output seq_done,
    output err_timeout
  );

  modport slave (
    output sw_rst_req,
    output dom_rdy,
    input  dom_rst_n,
    input  seq_busy,
    input  seq_done,
    input  err_timeout
  );

endinterface

// File: rtl/bb_reset_seq.sv
// -----------------------------------------------------------------------------
// bb_reset_seq
//
// Reset release sequencer. Consumes a reset that is already synchronous to
// clk, holds NUM_DOM downstream domain resets asserted for ASSERT_CYC edges,
// then releases the domains one at a time in index order. After each release
// it waits for that domain's ready (bounded by TIMEOUT_CYC edges) and then
// pauses GAP_CYC edges before releasing the next domain. A software reset
// request re-asserts every domain and restarts the sequence.
//
// Ports:
//   clk    sole clock
//   rst_n  synchronous active-low reset
//   bus    bb_reset_seq_if.master
//            sw_rst_req   in   software reset request, level-sensitive
//            dom_rdy      in   per-domain ready
//            dom_rst_n    out  per-domain reset, active-low, registered
//            seq_busy     out  sequence not complete, registered
//            seq_done     out  all domains released, registered
//            err_timeout  out  sticky per-domain ready-timeout, registered
//
// Parameters:
//   NUM_DOM      number of sequenced domains (>= 1)
//   ASSERT_CYC   edges all domains stay in reset after a (re)start (>= 1)
//   GAP_CYC      edges between ready/timeout of one domain and the next
//                release (>= 1)
//   TIMEOUT_CYC  maximum edges spent waiting for the current domain (>= 1)
//   CNT_W        counter width; each *_CYC must be <= 2**CNT_W
// -----------------------------------------------------------------------------
module bb_reset_seq #(
  parameter int unsigned NUM_DOM     = 3,
  parameter int unsigned ASSERT_CYC  = 4,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  bb_reset_seq_if.master bus
);

  localparam int unsigned IdxW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  // Terminal counts; each phase lasts N edges, so the counter stops at N-1.
  localparam logic [CNT_W-1:0] AssertLast  = CNT_W'(ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] GapLast     = CNT_W'(GAP_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IdxW-1:0]  LastIdx     = IdxW'(NUM_DOM - 1);

  typedef enum logic [1:0] {
    StAssert,
    StWaitRdy,
    StGap,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]    idx_q, idx_d;
  logic [NUM_DOM-1:0] dom_rst_q, dom_rst_d;
  logic [NUM_DOM-1:0] err_q, err_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;

  logic               rdy_cur;
  logic               wait_end;

  // Only the ready bit of the domain currently being waited on matters.
  assign rdy_cur  = bus.dom_rdy[idx_q];
  assign wait_end = rdy_cur || (cnt_q == TimeoutLast);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    dom_rst_d = dom_rst_q;
    err_d     = err_q;
    done_d    = done_q;

    if (bus.sw_rst_req) begin
      // Same update as rst_n, but one priority level below it.
      state_d   = StAssert;
      cnt_d     = '0;
      idx_d     = '0;
      dom_rst_d = '0;
      err_d     = '0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        StAssert: begin
          if (cnt_q == AssertLast) begin
            dom_rst_d[0] = 1'b1;
            cnt_d        = '0;
            idx_d        = '0;
            state_d      = StWaitRdy;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StWaitRdy: begin
          if (wait_end) begin
            // Ready wins over a timeout on the same edge; a timed-out domain
            // stays released and the sequence carries on.
            if (!rdy_cur) begin
              err_d[idx_q] = 1'b1;
            end
            if (idx_q == LastIdx) begin
              state_d = StDone;
              done_d  = 1'b1;
            end else begin
              idx_d   = idx_q + IdxW'(1);
              cnt_d   = '0;
              state_d = StGap;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StGap: begin
          if (cnt_q == GapLast) begin
            dom_rst_d[idx_q] = 1'b1;
            cnt_d            = '0;
            state_d          = StWaitRdy;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        StDone: begin
          dom_rst_d = '1;
          done_d    = 1'b1;
        end

        default: begin
          state_d = StAssert;
        end
      endcase
    end

    busy_d = !done_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StAssert;
      cnt_q     <= '0;
      idx_q     <= '0;
      dom_rst_q <= '0;
      err_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      dom_rst_q <= dom_rst_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.dom_rst_n   = dom_rst_q;
  assign bus.seq_busy    = busy_q;
  assign bus.seq_done    = done_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_bb_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_bb_reset_seq
//
// Scoreboard bench for bb_reset_seq. The driver applies inputs each cycle,
// advances a timestamp-based reference model at the clock edge and queues the
// expected outputs; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_bb_reset_seq;

  localparam int N           = 3;
  localparam int ASSERT_CYC  = 4;
  localparam int GAP_CYC     = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int CNT_W       = 8;
  localparam int W           = 2 * N + 2;

  typedef struct {
    string        tag;
    logic [W-1:0] val;  // {dom_rst_n, seq_busy, seq_done, err_timeout}
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  bb_reset_seq_if #(.NUM_DOM(N)) bus ();

  bb_reset_seq #(
    .NUM_DOM    (N),
    .ASSERT_CYC (ASSERT_CYC),
    .GAP_CYC    (GAP_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .CNT_W      (CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: tracks absolute edge numbers at which things happen.
  int           edge_n     = 0;
  int           m_rel      = 0;   // domains released so far
  bit           m_wait     = 0;   // waiting on domain m_rel-1
  int           m_deadline = 0;   // edge at which the current wait times out
  int           m_next_rel = 0;   // edge at which domain m_rel is released
  bit           m_done     = 0;
  logic [N-1:0] m_rst      = '0;
  logic [N-1:0] m_err      = '0;

  task automatic model_step(input logic r, input logic s, input logic [N-1:0] d);
    edge_n++;
    if (!r || s) begin
      m_rel      = 0;
      m_wait     = 0;
      m_next_rel = edge_n + ASSERT_CYC;
      m_done     = 0;
      m_rst      = '0;
      m_err      = '0;
    end else if (m_done) begin
      m_rst = '1;
    end else if (m_wait) begin
      if (d[m_rel-1] || edge_n == m_deadline) begin
        if (!d[m_rel-1]) m_err[m_rel-1] = 1'b1;
        m_wait = 0;
        if (m_rel == N) m_done = 1;
        else m_next_rel = edge_n + GAP_CYC;
      end
    end else if (edge_n == m_next_rel) begin
      m_rst[m_rel] = 1'b1;
      m_rel++;
      m_wait     = 1;
      m_deadline = edge_n + TIMEOUT_CYC;
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [N-1:0] d, input string tag);
    exp_t e;
    @(negedge clk);
    rst_n          = r;
    bus.sw_rst_req = s;
    bus.dom_rdy    = d;
    @(posedge clk);
    model_step(r, s, d);
    e.tag = tag;
    e.val = {m_rst, !m_done, m_done, m_err};
    exp_q.push_back(e);
  endtask

  task automatic run(input int n, input logic [N-1:0] d, input string tag);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, d, tag);
  endtask

  // Monitor: the DUT presents a new output state every cycle.
  exp_t         m_e;
  logic [W-1:0] got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e = exp_q.pop_front();
      got = {bus.dom_rst_n, bus.seq_busy, bus.seq_done, bus.err_timeout};
      checks++;
      if (got !== m_e.val) begin
        failures++;
        $display("FAIL %s @edge: got dom_rst_n=%b busy=%b done=%b err=%b, expected dom_rst_n=%b busy=%b done=%b err=%b",
                 m_e.tag, got[W-1 -: N], got[N+1], got[N], got[N-1:0],
                 m_e.val[W-1 -: N], m_e.val[N+1], m_e.val[N], m_e.val[N-1:0]);
      end
    end
  end

  int pct[N];

  initial begin
    bus.sw_rst_req = 1'b0;
    bus.dom_rdy    = '0;

    // Release timing with every domain ready.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'b111, "reset");
    run(14, 3'b111, "release_timing");

    // Domain 1 never ready -> timeout.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 3'b101, "reset2");
    run(30, 3'b101, "timeout");

    // Software reset pulse from DONE.
    step(1'b1, 1'b1, 3'b111, "sw_from_done");
    run(14, 3'b111, "sw_rerun");

    // Restart while in the gap before domain 2.
    step(1'b1, 1'b1, 3'b111, "sw_restart");
    run(8, 3'b111, "to_gap2");
    step(1'b1, 1'b1, 3'b111, "sw_mid_gap");
    run(14, 3'b111, "mid_rerun");

    // rst_n and sw_rst_req together during a wait.
    step(1'b1, 1'b1, 3'b101, "sw_restart2");
    run(9, 3'b101, "into_wait");
    step(1'b0, 1'b1, 3'b101, "rst_and_sw");
    run(14, 3'b111, "after_prio");
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 3'b111, "sw_held");
    run(14, 3'b111, "after_held");

    // Index isolation: other domains ready, domain 0 late.
    step(1'b0, 1'b0, 3'b110, "reset3");
    run(4 + 10, 3'b110, "idx_hold");
    run(12, 3'b111, "idx_go");

    // Randomized traffic with occasional resets and software requests.
    step(1'b0, 1'b0, '0, "reset_rand");
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] d;
      logic r, s;
      if (i % 40 == 0) begin
        for (int k = 0; k < N; k++) begin
          case ($urandom_range(0, 3))
            0:       pct[k] = 0;
            1:       pct[k] = 5;
            2:       pct[k] = 30;
            default: pct[k] = 100;
          endcase
        end
      end
      for (int k = 0; k < N; k++) d[k] = ($urandom_range(0, 99) < pct[k]);
      r = ($urandom_range(0, 299) != 0);
      s = ($urandom_range(0, 79) == 0);
      step(r, s, d, "random");
    end

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
